// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI command/pixel decoder: command codes,
// default panel extents and the decoder state encoding.
package tft_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int DEFAULT_X_MAX = 239;
  localparam int DEFAULT_Y_MAX = 319;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_PASET = 2'd2,
    ST_RAMWR = 2'd3
  } dec_state_t;

endpackage

// File: rtl/spi_byte_receiver.sv
// SPI mode-0 serial-to-byte front end: synchronises the pins into the clk
// domain, shifts MSB first on spi_clk rising edges and strobes each full byte.
module spi_byte_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic       sclk_s, mosi_s, dc_s, cs_s;
  logic       sclk_prev;
  logic       sclk_rise;
  logic [2:0] bit_cnt;
  logic [6:0] shift;

  // Chip select resets to its inactive (high) level so nothing is sampled
  // until the host really selects the device.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
    end else begin
      sclk_sync[0] <= spi_clk;
      mosi_sync[0] <= spi_mosi;
      dc_sync[0]   <= spi_dc;
      cs_sync[0]   <= spi_cs;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        dc_sync[i]   <= dc_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
      end
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_prev  <= 1'b0;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      sclk_prev  <= sclk_s;
      if (cs_s) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift   <= {shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift, mosi_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end

endmodule

// File: rtl/tft_spi_decoder.sv
// TFT panel SPI snooper: decodes CASET/PASET/RAMWR traffic into a window,
// a pixel cursor and one RGB565 pixel strobe per pair of RAMWR data bytes.
module tft_spi_decoder
  import tft_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int X_MAX       = DEFAULT_X_MAX,
  parameter int Y_MAX       = DEFAULT_Y_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  input  logic        spi_cs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pixel_valid,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_color,
  output logic [7:0]  last_cmd
);

  localparam logic [8:0] X_END = 9'(X_MAX);
  localparam logic [8:0] Y_END = 9'(Y_MAX);

  dec_state_t state;
  logic [2:0] param_idx;
  logic       start_hi, end_hi;
  logic [7:0] start_lo;
  logic [8:0] xs, xe, ys, ye;
  logic [8:0] cur_x, cur_y;
  logic [8:0] nxt_x, nxt_y;
  logic       phase;
  logic [7:0] color_hi;

  spi_byte_receiver #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc)
  );

  // A start beyond the end fails x<xe immediately, so every pixel wraps a row.
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (cur_x < xe) begin
      nxt_x = cur_x + 9'd1;
    end else begin
      nxt_x = xs;
      nxt_y = (cur_y >= ye) ? ys : cur_y + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      param_idx   <= 3'd0;
      start_hi    <= 1'b0;
      start_lo    <= 8'd0;
      end_hi      <= 1'b0;
      xs          <= 9'd0;
      xe          <= X_END;
      ys          <= 9'd0;
      ye          <= Y_END;
      cur_x       <= 9'd0;
      cur_y       <= 9'd0;
      phase       <= 1'b0;
      color_hi    <= 8'd0;
      last_cmd    <= 8'd0;
      pixel_valid <= 1'b0;
      pixel_x     <= 9'd0;
      pixel_y     <= 9'd0;
      pixel_color <= 16'd0;
    end else begin
      pixel_valid <= 1'b0;
      if (byte_valid && !byte_dc) begin
        last_cmd  <= byte_data;
        param_idx <= 3'd0;
        phase     <= 1'b0;
        case (byte_data)
          CMD_CASET: state <= ST_CASET;
          CMD_PASET: state <= ST_PASET;
          CMD_RAMWR: begin
            state <= ST_RAMWR;
            cur_x <= xs;
            cur_y <= ys;
          end
          default:   state <= ST_IDLE;
        endcase
      end else if (byte_valid) begin
        case (state)
          ST_CASET, ST_PASET: begin
            // Only the bits that survive 9-bit truncation are staged.
            if (param_idx < 3'd4) begin
              param_idx <= param_idx + 3'd1;
              case (param_idx)
                3'd0:    start_hi <= byte_data[0];
                3'd1:    start_lo <= byte_data;
                3'd2:    end_hi   <= byte_data[0];
                default: begin
                  if (state == ST_CASET) begin
                    xs <= {start_hi, start_lo};
                    xe <= {end_hi, byte_data};
                  end else begin
                    ys <= {start_hi, start_lo};
                    ye <= {end_hi, byte_data};
                  end
                end
              endcase
            end
          end
          ST_RAMWR: begin
            if (!phase) begin
              color_hi <= byte_data;
              phase    <= 1'b1;
            end else begin
              phase       <= 1'b0;
              pixel_valid <= 1'b1;
              pixel_x     <= cur_x;
              pixel_y     <= cur_y;
              pixel_color <= {color_hi, byte_data};
              cur_x       <= nxt_x;
              cur_y       <= nxt_y;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
